// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared constants, loader state type and bank address helper
// Purpose: default geometry of the image/weight buffers, memory base addresses,
//          and the coefficient loader state encoding.
// Ports:   none (package)
package ann_pkg;

   localparam int ANN_DATA_W    = 16;
   localparam int ANN_ADDR_W    = 16;
   localparam int ANN_IMG_WORDS = 64;
   localparam int ANN_W_ROWS    = 64;
   localparam int ANN_W_COLS    = 16;

   localparam logic [15:0] IMG_BASE = 16'h0000;
   localparam logic [15:0] W0_BASE  = 16'h0100;
   localparam logic [15:0] W1_BASE  = 16'h0500;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IMG_REQ,
      ST_IMG_WAIT,
      ST_W_REQ,
      ST_W_WAIT,
      ST_DONE
   } loader_state_t;

   function automatic logic [15:0] bank_base(input logic i_sel);
      return i_sel ? W1_BASE : W0_BASE;
   endfunction

endpackage

// File: rtl/mem_word_reader.sv
// rtl/mem_word_reader.sv - single outstanding word read towards external memory
// Purpose: issues one read when i_start is high, then waits (unbounded) for
//          mem_rd_valid and strobes o_word_done with the returned word.
// Ports:   clk, n_rst            clock, async active-low reset
//          i_start, i_addr       read request from the loader FSM
//          mem_rd_en, mem_addr   memory request (same cycle as i_start)
//          mem_rd_data/valid     memory response
//          o_data, o_word_done   returned word and its 1-cycle strobe
module mem_word_reader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_word_done
);

   logic r_outstanding;
   logic w_done;

   // A valid with no read in flight is a stray response and is dropped here.
   assign w_done      = r_outstanding & mem_rd_valid;
   assign mem_rd_en   = i_start;
   assign mem_addr    = i_addr;
   assign o_data      = mem_rd_data;
   assign o_word_done = w_done;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_outstanding <= 1'b0;
      end else if (i_start) begin
         r_outstanding <= 1'b1;
      end else if (w_done) begin
         r_outstanding <= 1'b0;
      end
   end

endmodule

// File: rtl/coef_loader.sv
// rtl/coef_loader.sv - loads image and weight bank from word memory into ANN buffers
// Purpose: image_start loads image + bank 0; request_coef loads bank coef_select.
//          Requests arriving while busy are held in 1-deep pending flags.
// Ports:   clk, n_rst                 clock, async active-low reset
//          image_start, request_coef  1-cycle start pulses; coef_select = bank
//          mem_rd_en/mem_addr         word read request
//          mem_rd_data/mem_rd_valid   word read response
//          image, weights             buffers driving the ANN
//          image_weights_loaded       1-cycle completion pulse
//          busy                       high whenever not idle
module coef_loader
   import ann_pkg::*;
#(
   parameter int DATA_W    = ANN_DATA_W,
   parameter int IMG_WORDS = ANN_IMG_WORDS,
   parameter int W_ROWS    = ANN_W_ROWS,
   parameter int W_COLS    = ANN_W_COLS,
   parameter int ADDR_W    = ANN_ADDR_W
) (
   input  logic                                       clk,
   input  logic                                       n_rst,
   input  logic                                       image_start,
   input  logic                                       request_coef,
   input  logic                                       coef_select,
   output logic                                       mem_rd_en,
   output logic [ADDR_W-1:0]                          mem_addr,
   input  logic [DATA_W-1:0]                          mem_rd_data,
   input  logic                                       mem_rd_valid,
   output logic [IMG_WORDS-1:0][DATA_W-1:0]           image,
   output logic [W_ROWS-1:0][W_COLS-1:0][DATA_W-1:0]  weights,
   output logic                                       image_weights_loaded,
   output logic                                       busy
);

   localparam int W_WORDS   = W_ROWS * W_COLS;
   localparam int IDX_W     = $clog2(W_WORDS);
   localparam int IMG_IDX_W = $clog2(IMG_WORDS);

   loader_state_t r_state, w_next;
   logic [IDX_W-1:0]  r_idx;
   logic              r_bank;
   logic              r_pend_req, r_pend_bank, r_pend_img;
   logic [IMG_WORDS-1:0][DATA_W-1:0] r_image;
   // Flat storage: entry r*W_COLS+c is exactly weights[r][c] (row-major).
   logic [W_WORDS-1:0][DATA_W-1:0]   r_weights;

   logic              w_start;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_word_done;
   logic              w_img_last, w_w_last;
   logic              w_req_any, w_img_any;

   mem_word_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_reader (
      .clk          (clk),
      .n_rst        (n_rst),
      .i_start      (w_start),
      .i_addr       (w_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_data  (mem_rd_data),
      .mem_rd_valid (mem_rd_valid),
      .o_data       (w_data),
      .o_word_done  (w_word_done)
   );

   assign w_img_last = (r_idx == IDX_W'(IMG_WORDS - 1));
   assign w_w_last   = (r_idx == IDX_W'(W_WORDS - 1));
   // In DONE a pulse arriving that very cycle counts as pending too.
   assign w_req_any  = r_pend_req | request_coef;
   assign w_img_any  = r_pend_img | image_start;

   assign image                = r_image;
   assign weights              = r_weights;
   assign image_weights_loaded = (r_state == ST_DONE);
   assign busy                 = (r_state != ST_IDLE);

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_addr  = '0;
      case (r_state)
         ST_IDLE: begin
            if (image_start)       w_next = ST_IMG_REQ;
            else if (request_coef) w_next = ST_W_REQ;
         end
         ST_IMG_REQ: begin
            w_start = 1'b1;
            w_addr  = ADDR_W'(IMG_BASE) + ADDR_W'(r_idx);
            w_next  = ST_IMG_WAIT;
         end
         ST_IMG_WAIT: begin
            if (w_word_done) w_next = w_img_last ? ST_W_REQ : ST_IMG_REQ;
         end
         ST_W_REQ: begin
            w_start = 1'b1;
            w_addr  = ADDR_W'(bank_base(r_bank)) + ADDR_W'(r_idx);
            w_next  = ST_W_WAIT;
         end
         ST_W_WAIT: begin
            if (w_word_done) w_next = w_w_last ? ST_DONE : ST_W_REQ;
         end
         ST_DONE: begin
            // Pending coefficient reload is serviced before a pending image.
            if (w_req_any)      w_next = ST_W_REQ;
            else if (w_img_any) w_next = ST_IMG_REQ;
            else                w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_bank      <= 1'b0;
         r_pend_req  <= 1'b0;
         r_pend_bank <= 1'b0;
         r_pend_img  <= 1'b0;
         r_image     <= '0;
         r_weights   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               r_idx <= '0;
               if (image_start) begin
                  r_bank <= 1'b0;
                  if (request_coef) begin
                     r_pend_req  <= 1'b1;
                     r_pend_bank <= coef_select;
                  end
               end else if (request_coef) begin
                  r_bank <= coef_select;
               end
            end
            ST_DONE: begin
               r_idx <= '0;
               if (w_req_any) begin
                  r_bank     <= request_coef ? coef_select : r_pend_bank;
                  r_pend_req <= 1'b0;
                  r_pend_img <= w_img_any;
               end else begin
                  r_bank     <= 1'b0;
                  r_pend_img <= 1'b0;
               end
            end
            default: begin
               if (request_coef) begin
                  r_pend_req  <= 1'b1;
                  r_pend_bank <= coef_select;
               end
               if (image_start) r_pend_img <= 1'b1;
               if (w_word_done && r_state == ST_IMG_WAIT) begin
                  r_image[r_idx[IMG_IDX_W-1:0]] <= w_data;
                  r_idx <= w_img_last ? '0 : r_idx + IDX_W'(1);
               end else if (w_word_done && r_state == ST_W_WAIT) begin
                  r_weights[r_idx] <= w_data;
                  if (!w_w_last) r_idx <= r_idx + IDX_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coef_loader.sv
// tb/tb_coef_loader.sv - self-checking bench for coef_loader
module tb_coef_loader;

   logic clk = 1'b0;
   logic n_rst, image_start, request_coef, coef_select;
   logic mem_rd_en;
   logic [15:0] mem_addr, mem_rd_data;
   logic mem_rd_valid;
   logic [63:0][15:0] image;
   logic [63:0][15:0][15:0] weights;
   logic image_weights_loaded, busy;

   always #5 clk = ~clk;

   coef_loader dut (
      .clk(clk), .n_rst(n_rst), .image_start(image_start), .request_coef(request_coef),
      .coef_select(coef_select), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .image(image),
      .weights(weights), .image_weights_loaded(image_weights_loaded), .busy(busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pulses = 0;
   int last_pulse_cyc = 0;
   int stray_req_cnt = 0;
   logic [15:0] key = 16'h0000;
   bit rand_delay = 1'b0;
   logic [15:0] rd_log[$];
   logic [15:0] exp_addr[$];
   logic [15:0] m_img[64];
   logic [15:0] m_w[1024];

   typedef struct {
      bit img; bit req; bit sel; bit rdly;
      logic [15:0] key; int exp_reads; int exp_pulses;
   } vec_t;
   vec_t tbl[6];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (image_weights_loaded === 1'b1) begin
         pulses++;
         last_pulse_cyc = cyc;
      end
   end

   function automatic logic [15:0] memval(input logic [15:0] a);
      return a ^ key;
   endfunction

   // Memory: answers each read after 1 + (0..5 random) cycles; can inject stray valids.
   initial begin : mem_model
      int d;
      int stray_done;
      stray_done = 0;
      mem_rd_valid = 1'b0;
      mem_rd_data = '0;
      forever begin
         @(negedge clk);
         if (n_rst === 1'b1 && mem_rd_en === 1'b1) begin
            rd_log.push_back(mem_addr);
            d = rand_delay ? int'($urandom_range(0, 5)) : 0;
            @(posedge clk);
            repeat (d) @(posedge clk);
            #1 mem_rd_data = memval(rd_log[$]);
            mem_rd_valid = 1'b1;
            @(posedge clk);
            #1 mem_rd_valid = 1'b0;
            mem_rd_data = 16'($urandom);
         end else if (stray_req_cnt != stray_done) begin
            stray_done++;
            @(posedge clk);
            #1 mem_rd_valid = 1'b1;
            mem_rd_data = 16'hBAD0;
            @(posedge clk);
            #1 mem_rd_valid = 1'b0;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_bank_job(input bit b);
      logic [15:0] base;
      base = b ? 16'h0500 : 16'h0100;
      for (int k = 0; k < 1024; k++) begin
         exp_addr.push_back(base + 16'(k));
         m_w[k] = memval(base + 16'(k));
      end
   endtask

   task automatic push_image_job();
      for (int i = 0; i < 64; i++) begin
         exp_addr.push_back(16'(i));
         m_img[i] = memval(16'(i));
      end
      push_bank_job(1'b0);
   endtask

   function automatic int img_mism();
      int b = 0;
      for (int i = 0; i < 64; i++) if (image[i] !== m_img[i]) b++;
      return b;
   endfunction

   function automatic int w_mism();
      int b = 0;
      for (int k = 0; k < 1024; k++) if (weights[k / 16][k % 16] !== m_w[k]) b++;
      return b;
   endfunction

   task automatic check_all(input string tag, input int rb);
      int n;
      int bad;
      n = rd_log.size() - rb;
      bad = 0;
      check({tag, "_reads"}, n, exp_addr.size());
      for (int i = 0; i < n && i < exp_addr.size(); i++)
         if (rd_log[rb + i] !== exp_addr[i]) bad++;
      check({tag, "_addr_seq"}, bad, 0);
      check({tag, "_image"}, img_mism(), 0);
      check({tag, "_weights"}, w_mism(), 0);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy still %0b after %0d cycles", tag, busy, n);
      end
   endtask

   task automatic wait_pulse(input string tag, input int p0, input int budget);
      int n = 0;
      while (pulses == p0 && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL %s_pulse_timeout: no loaded pulse after %0d cycles", tag, n);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 64; i++) m_img[i] = '0;
      for (int k = 0; k < 1024; k++) m_w[k] = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_loaded"}, 32'(image_weights_loaded), 0);
      check({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      check({tag, "_addr"}, 32'(mem_addr), 0);
      check({tag, "_image"}, img_mism(), 0);
      check({tag, "_weights"}, w_mism(), 0);
   endtask

   initial begin : main
      int rb, p0, c0, n;
      image_start = 1'b0;
      request_coef = 1'b0;
      coef_select = 1'b0;
      n_rst = 1'b0;
      clear_model();
      tick(3);
      check_zero("reset");
      n_rst = 1'b1;
      tick(2);

      // Full image + bank 0 load with mem[a]=a and exact pulse timing.
      key = 16'h0000;
      rand_delay = 1'b0;
      exp_addr.delete();
      rb = rd_log.size();
      p0 = pulses;
      push_image_job();
      image_start = 1'b1;
      c0 = cyc;
      tick();
      image_start = 1'b0;
      wait_pulse("t1", p0, 5000);
      check("t1_pulse_cycle", last_pulse_cyc - c0, 2177);
      check("t1_busy_after", 32'(busy), 0);
      check("t1_pulses", pulses - p0, 1);
      check("t1_img5", 32'(image[5]), 32'h0005);
      check("t1_w3_7", 32'(weights[3][7]), 32'h0137);
      check_all("t1", rb);

      tbl[0] = '{img:1'b1, req:1'b0, sel:1'b0, rdly:1'b0, key:16'h1111, exp_reads:1088, exp_pulses:1};
      tbl[1] = '{img:1'b0, req:1'b1, sel:1'b1, rdly:1'b0, key:16'h2222, exp_reads:1024, exp_pulses:1};
      tbl[2] = '{img:1'b0, req:1'b1, sel:1'b0, rdly:1'b1, key:16'h3333, exp_reads:1024, exp_pulses:1};
      tbl[3] = '{img:1'b1, req:1'b0, sel:1'b0, rdly:1'b1, key:16'h4444, exp_reads:1088, exp_pulses:1};
      tbl[4] = '{img:1'b1, req:1'b1, sel:1'b0, rdly:1'b0, key:16'h5555, exp_reads:2112, exp_pulses:2};
      tbl[5] = '{img:1'b1, req:1'b1, sel:1'b1, rdly:1'b1, key:16'h6666, exp_reads:2112, exp_pulses:2};

      for (int v = 0; v < 6; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         key = tbl[v].key;
         rand_delay = tbl[v].rdly;
         exp_addr.delete();
         rb = rd_log.size();
         p0 = pulses;
         if (tbl[v].img) push_image_job();
         if (tbl[v].req) push_bank_job(tbl[v].sel);
         image_start = tbl[v].img;
         request_coef = tbl[v].req;
         coef_select = tbl[v].sel;
         tick();
         image_start = 1'b0;
         request_coef = 1'b0;
         coef_select = 1'b0;
         wait_idle(tag, 30000);
         check({tag, "_exp_reads"}, rd_log.size() - rb, tbl[v].exp_reads);
         check({tag, "_pulses"}, pulses - p0, tbl[v].exp_pulses);
         check_all(tag, rb);
         tick(2);
      end

      // Stray valid while idle must not write anything.
      p0 = pulses;
      stray_req_cnt++;
      tick(6);
      check("stray_image", img_mism(), 0);
      check("stray_weights", w_mism(), 0);
      check("stray_busy", 32'(busy), 0);
      check("stray_pulses", pulses - p0, 0);

      // Request for bank 1 during an image load: serviced right after the first pulse.
      key = 16'h5A5A;
      rand_delay = 1'b0;
      exp_addr.delete();
      rb = rd_log.size();
      p0 = pulses;
      push_image_job();
      push_bank_job(1'b1);
      image_start = 1'b1;
      tick();
      image_start = 1'b0;
      tick(200);
      request_coef = 1'b1;
      coef_select = 1'b1;
      tick();
      request_coef = 1'b0;
      coef_select = 1'b0;
      wait_pulse("t4", p0, 5000);
      check("t4_first_pulses", pulses - p0, 1);
      check("t4_busy_next", 32'(busy), 1);
      check("t4_rd_en_next", 32'(mem_rd_en), 1);
      check("t4_addr_next", 32'(mem_addr), 32'h0500);
      wait_idle("t4", 5000);
      check("t4_pulses", pulses - p0, 2);
      check_all("t4", rb);

      // Reset at word 500 aborts the load; a fresh image_start reloads fully.
      key = 16'h3C3C;
      rand_delay = 1'b1;
      rb = rd_log.size();
      p0 = pulses;
      image_start = 1'b1;
      tick();
      image_start = 1'b0;
      n = 0;
      while (rd_log.size() - rb < 500 && n < 10000) begin
         tick();
         n++;
      end
      check("t5_reached_500", 32'(rd_log.size() - rb >= 500), 1);
      n_rst = 1'b0;
      #1;
      clear_model();
      check_zero("t5_rst");
      tick(10);
      check("t5_no_pulse", pulses - p0, 0);
      n_rst = 1'b1;
      tick(10);
      exp_addr.delete();
      rb = rd_log.size();
      p0 = pulses;
      push_image_job();
      image_start = 1'b1;
      tick();
      image_start = 1'b0;
      wait_idle("t5", 20000);
      check("t5_pulses", pulses - p0, 1);
      check_all("t5", rb);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
